// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM encodings, counter widths and a saturating increment helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int CNT_W  = 32;
    localparam int DCNT_W = 3;
    localparam int WCNT_W = 8;

    function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
        return (v == {WCNT_W{1'b1}}) ? v : v + {{(WCNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction currently in ID. Purely combinational.
module hazard_detect (
    input  logic [4:0] id_ex_rd_i,
    input  logic       id_ex_memread_i,
    input  logic [4:0] if_id_rs1_i,
    input  logic [4:0] if_id_rs2_i,
    output logic       load_use_o
);

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard
    assign load_use_o = id_ex_memread_i && (id_ex_rd_i != 5'd0) &&
                        ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and halt/drain controller for the 5-stage pipeline.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_MemRead,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_flush,
    output logic             halt_ack,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                halt_ack_q, mem_timeout_q, mem_timeout_d;
    logic                load_use_s, stall_inc_s, flush_inc_s;

    hazard_detect u_hazard (
        .id_ex_rd_i      (ID_EX_RD),
        .id_ex_memread_i (ID_EX_MemRead),
        .if_id_rs1_i     (IF_ID_RS1),
        .if_id_rs2_i     (IF_ID_RS2),
        .load_use_o      (load_use_s)
    );

    // Next-state and pipe controls; priority mem_busy > branch > load-use > halt sequencing
    always_comb begin
        state_d      = state_q;
        dcnt_d       = dcnt_q;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_write  = 1'b1;
        EX_MEM_write = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        if (reset) begin
            state_d = RUN;
            dcnt_d  = {DCNT_W{1'b0}};
        end else begin
            case (state_q)
                RUN, DRAIN: begin
                    if (mem_busy) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_write  = 1'b0;
                        EX_MEM_write = 1'b0;
                        MEM_WB_flush = 1'b1;
                        stall_inc_s  = 1'b1;
                    end else if (branch_taken) begin
                        IF_ID_flush  = 1'b1;
                        ID_EX_flush  = 1'b1;
                        flush_inc_s  = 1'b1;
                        // the branch cycle already injects one bubble into the drain
                        dcnt_d = (state_q == DRAIN) ? 3'd1 : dcnt_q;
                    end else if (load_use_s) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_flush  = 1'b1;
                        stall_inc_s  = 1'b1;
                    end else if (state_q == RUN) begin
                        if (halt_req) begin
                            state_d     = DRAIN;
                            dcnt_d      = 3'd0;
                            PC_write    = 1'b0;
                            IF_ID_flush = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        // PC is held while draining, so aborting back to RUN loses nothing
                        PC_write    = 1'b0;
                        IF_ID_flush = 1'b1;
                        dcnt_d      = dcnt_q + 3'd1;
                        if (!halt_req) begin
                            state_d = RUN;
                        end else if (dcnt_q == 3'(DRAIN_CYCLES - 1)) begin
                            state_d = HALTED;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                HALTED: begin
                    PC_write     = 1'b0;
                    IF_ID_flush  = 1'b1;
                    ID_EX_flush  = 1'b1;
                    MEM_WB_flush = 1'b1;
                    state_d      = halt_req ? HALTED : RUN;
                end
                default: begin
                    state_d = RUN;
                    dcnt_d  = {DCNT_W{1'b0}};
                end
            endcase
        end
    end

    // Memory wait counter and sticky timeout flag
    always_comb begin
        wcnt_d        = mem_busy ? sat_inc(wcnt_q) : {WCNT_W{1'b0}};
        mem_timeout_d = mem_timeout_q || (wcnt_d >= WCNT_W'(MEM_TIMEOUT));
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            dcnt_q        <= {DCNT_W{1'b0}};
            wcnt_q        <= {WCNT_W{1'b0}};
            halt_ack_q    <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            wcnt_q        <= wcnt_d;
            halt_ack_q    <= (state_d == HALTED);
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign halt_ack    = halt_ack_q;
    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_events_q;

    // Performance counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_events_q <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_q + {{(CNT_W-1){1'b0}}, stall_inc_s};
            flush_events_q <= flush_events_q + {{(CNT_W-1){1'b0}}, flush_inc_s};
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    logic unused_perf_s;
    assign unused_perf_s = stall_inc_s ^ flush_inc_s;
    assign stall_cycles  = {CNT_W{1'b0}};
    assign flush_events  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl plus hand-written
// sequences for drain/halt, memory wait and timeout behaviour.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic        mem_read, br, busy, halt;
    logic        pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f;
    logic        halt_ack, mem_timeout;
    logic [31:0] stall_cycles, flush_events;
    logic [6:0]  ctl_s;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(255)) dut (
        .clk           (clk),
        .reset         (reset),
        .IF_ID_RS1     (rs1),
        .IF_ID_RS2     (rs2),
        .ID_EX_RD      (rd),
        .ID_EX_MemRead (mem_read),
        .branch_taken  (br),
        .mem_busy      (busy),
        .halt_req      (halt),
        .PC_write      (pc_w),
        .IF_ID_write   (ifid_w),
        .ID_EX_write   (idex_w),
        .EX_MEM_write  (exmem_w),
        .IF_ID_flush   (ifid_f),
        .ID_EX_flush   (idex_f),
        .MEM_WB_flush  (memwb_f),
        .halt_ack      (halt_ack),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    always #5 clk = ~clk;

    // {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
    assign ctl_s = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f};

    localparam logic [6:0] C_DEF   = 7'b1111000;
    localparam logic [6:0] C_LU    = 7'b0011010;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_BUSY  = 7'b0000001;
    localparam logic [6:0] C_DRAIN = 7'b0111100;
    localparam logic [6:0] C_HALT  = 7'b0111111;

    typedef struct {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       busy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        mem_read = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; br = 1'b0; busy = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF};
        vecs[1] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, C_LU};
        vecs[2] = '{1'b1, 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, C_LU};
        vecs[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF};
        vecs[4] = '{1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, C_DEF};
        vecs[5] = '{1'b1, 5'd5, 5'd4, 5'd6, 1'b0, 1'b0, C_DEF};
        vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BR};
        vecs[7] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, C_BR};
        vecs[8] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_BUSY};
        vecs[9] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, C_BUSY};

        reset = 1'b1; halt = 1'b0; quiet();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'(ctl_s), 32'(C_DEF));
        chk("reset_ack", 32'(halt_ack), 32'd0);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_flush", flush_events, 32'd0);

        // single-cycle controls in RUN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_read = vecs[i].mr; rd = vecs[i].rd; rs1 = vecs[i].rs1;
            rs2 = vecs[i].rs2; br = vecs[i].br; busy = vecs[i].busy;
            #1;
            chk($sformatf("vec%0d", i), 32'(ctl_s), 32'(vecs[i].exp));
        end
        @(negedge clk) quiet();
        #1;
        chk("perf_stall_tbl", stall_cycles, PERF ? 32'd4 : 32'd0);
        chk("perf_flush_tbl", flush_events, PERF ? 32'd2 : 32'd0);

        // mem_busy holds off a pending branch for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) busy = 1'b1; br = 1'b1;
            #1;
            chk($sformatf("busy_br%0d", i), 32'(ctl_s), 32'(C_BUSY));
        end
        @(negedge clk) busy = 1'b0;
        #1;
        chk("br_after_busy", 32'(ctl_s), 32'(C_BR));
        @(negedge clk) quiet();
        #1;
        chk("perf_stall_a", stall_cycles, PERF ? 32'd7 : 32'd0);
        chk("perf_flush_a", flush_events, PERF ? 32'd3 : 32'd0);

        // quiet halt: four drain cycles, ack at the fifth edge
        @(negedge clk) halt = 1'b1;
        #1;
        chk("halt_run_ctl", 32'(ctl_s), 32'(C_DRAIN));
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("halt_ack_e%0d", e), 32'(halt_ack), (e == 5) ? 32'd1 : 32'd0);
            chk($sformatf("halt_ctl_e%0d", e), 32'(ctl_s), (e == 5) ? 32'(C_HALT) : 32'(C_DRAIN));
        end
        @(negedge clk) busy = 1'b1;
        #1;
        chk("halted_ignores_busy", 32'(ctl_s), 32'(C_HALT));
        @(negedge clk) busy = 1'b0; halt = 1'b0;
        @(posedge clk);
        #1;
        chk("unhalt_ack", 32'(halt_ack), 32'd0);
        chk("unhalt_ctl", 32'(ctl_s), 32'(C_DEF));

        // reset in the middle of a drain
        @(negedge clk) halt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("rst_drain_ctl", 32'(ctl_s), 32'(C_DEF));
        @(posedge clk);
        #1;
        chk("rst_drain_ack", 32'(halt_ack), 32'd0);
        @(negedge clk) reset = 1'b0; halt = 1'b0;
        #1;
        chk("rst_drain_run", 32'(ctl_s), 32'(C_DEF));
        chk("rst_perf_stall", stall_cycles, 32'd0);

        // load-use at dcnt=2 delays the ack by one edge
        @(negedge clk) halt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5;
        #1;
        chk("drain_lu_ctl", 32'(ctl_s), 32'(C_LU));
        @(negedge clk) quiet();
        #1;
        chk("drain_after_lu", 32'(ctl_s), 32'(C_DRAIN));
        @(posedge clk);
        #1;
        chk("drain_lu_ack_e5", 32'(halt_ack), 32'd0);
        @(posedge clk);
        #1;
        chk("drain_lu_ack_e6", 32'(halt_ack), 32'd1);

        // halt re-asserted the cycle after leaving HALTED
        @(negedge clk) halt = 1'b0;
        @(posedge clk);
        #1;
        chk("reenter_ack_low", 32'(halt_ack), 32'd0);
        @(negedge clk) halt = 1'b1;
        #1;
        chk("reenter_ctl", 32'(ctl_s), 32'(C_DRAIN));
        repeat (4) @(posedge clk);
        #1;
        chk("reenter_ack_e4", 32'(halt_ack), 32'd0);
        @(posedge clk);
        #1;
        chk("reenter_ack_e5", 32'(halt_ack), 32'd1);
        @(negedge clk) halt = 1'b0;
        @(posedge clk);

        // memory timeout after 255 consecutive busy cycles, sticky until reset
        @(negedge clk) busy = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            @(posedge clk);
            #1;
            if (i == 254) chk("timeout_e254", 32'(mem_timeout), 32'd0);
            if (i == 255) chk("timeout_e255", 32'(mem_timeout), 32'd1);
        end
        @(negedge clk) busy = 1'b0;
        @(posedge clk);
        #1;
        chk("timeout_sticky", 32'(mem_timeout), 32'd1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("timeout_cleared", 32'(mem_timeout), 32'd0);
        @(negedge clk) reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
